vme_slave_ctrl: RTL
===================

Name: vme_slave_ctrl

Overview:
VME A16/D16 slave bus-cycle controller for the board's control register block at 0x7C80–0x7CA4.
- Synchronises the asynchronous VME strobes, latches address and address modifier, and presents the address to the register address decoder.
- Uses the decoder's hit indication to qualify the cycle.
- Issues single-cycle read/write strobes to the register file and runs the DTACK handshake back to the bus.
- Non-hit, wrong-AM and byte cycles are ignored (no DTACK), so the crate's bus timer terminates them.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (min 2).
AM_SUP, 6'h2D, accepted A16 supervisory address modifier.
AM_USR, 6'h29, accepted A16 non-privileged address modifier.
DTACK_DELAY, 2, CLK cycles from strobe pulse to DTACK assertion (min 1; allows read data to settle).
DS_TIMEOUT, 255, max CLK cycles waiting for data strobes after a valid address before giving up.

Ports:
CLK  in  1  system clock; all state on rising edge.
nRESET  in  1  asynchronous active-low reset.
VME_AS_N  in  1  address strobe, async.
VME_DS0_N  in  1  data strobe 0, async.
VME_DS1_N  in  1  data strobe 1, async.
VME_WRITE_N  in  1  0 = write cycle.
VME_AM  in  6  address modifier.
VME_A  in  15  address lines A[15:1].
VME_D_IN  in  16  data bus input.
ADDR  out  16  latched address {A[15:1],1'b0}, to address decoder.
ADDR_HIT  in  1  OR of all decoder select outputs.
RD_DATA  in  16  read data from register mux, valid 1 cycle after RD_STB.
WR_DATA  out  16  latched write data.
WR_STB  out  1  1-cycle register write strobe.
RD_STB  out  1  1-cycle register read strobe.
VME_D_OUT  out  16  read data to bus transceiver.
VME_D_OE  out  1  data bus drive enable.
VME_DTACK_N  out  1  DTACK level.
VME_DTACK_OE  out  1  DTACK drive enable (open-collector emulation).

Behaviour:
- Reset: ADDR=0, WR_DATA=0, VME_D_OUT=0, WR_STB=RD_STB=0, VME_D_OE=0, VME_DTACK_N=1, VME_DTACK_OE=0, FSM=IDLE, counters=0. Reset is honoured in every state, including ACK; the bus is released immediately.
- All four VME strobe inputs pass through SYNC_STAGES flops. The AS falling edge is detected on the synchronised signal (previous high, current low). VME_A, VME_AM, VME_D_IN and VME_WRITE_N are sampled only in the states below.
- IDLE: on the AS falling edge, latch ADDR and AM, then go to DECODE. With SYNC_STAGES=2, ADDR is valid 3 cycles after the AS pin falls.
- DECODE (1 cycle, decoder settles): if AM is not AM_SUP/AM_USR, or ADDR_HIT=0, go to IGNORE; else go to WAIT_DS with the timeout counter cleared.
- WAIT_DS: on either synced DS low, go to DS_SETTLE. If the counter reaches DS_TIMEOUT, go to IGNORE.
- DS_SETTLE (1 cycle): if both DS are low, latch WRITE_N and go to STROBE. Otherwise (byte access, unsupported) go to IGNORE.
- STROBE (1 cycle):
  - Write: WR_DATA <= VME_D_IN and WR_STB=1 in the same cycle.
  - Read: RD_STB=1.
  - Then go to DELAY with the counter loaded to DTACK_DELAY.
- DELAY:
  - Read: VME_D_OUT <= RD_DATA on the first DELAY cycle; VME_D_OE=1 from that cycle.
  - When the count expires, go to ACK.
- ACK: VME_DTACK_OE=1, VME_DTACK_N=0. Hold until both synced DS are high, then go to RELEASE.
- RELEASE (1 cycle): VME_DTACK_N=1 with OE still 1 (active pull-up), VME_D_OE=0. Next cycle VME_DTACK_OE=0, go to IDLE.
- IGNORE: no outputs driven. Wait for synced AS high, then go to IDLE.
- A synced AS high in DECODE/WAIT_DS/DS_SETTLE aborts to IDLE with no strobe.
- AS high after STROBE does not abort; the cycle completes through ACK/RELEASE.
- The next cycle requires a new AS falling edge. AS held low after RELEASE starts nothing.
- WR_STB and RD_STB never both asserted; at most one strobe per bus cycle.

Test Plan:
- Write 0xA5A5 to 0x7C84 with AM=0x2D → ADDR=0x7C84, WR_STB one pulse with WR_DATA=0xA5A5, DTACK_N low 1+DTACK_DELAY cycles after STROBE, released one cycle after both DS high, OE then low.
- Read 0x7CA2 with AM=0x29, RD_DATA=0x1234 → single RD_STB, VME_D_OUT=0x1234 with D_OE=1 before DTACK asserts; D_OE=0 in RELEASE.
- Address 0x7C92 (ADDR_HIT=0), and separately AM=0x39 at 0x7C80 → no strobe, DTACK_OE stays 0; FSM returns to IDLE after AS high.
- Byte cycle at 0x7C86 (only DS0 low) → IGNORE, no strobe, no DTACK. DS never asserted for 300 cycles → timeout to IGNORE.
- AS deasserted during WAIT_DS → IDLE, no strobe. Follow-up write to 0x7C88 completes normally.
- nRESET asserted while in ACK → DTACK_N=1, DTACK_OE=0, D_OE=0 asynchronously. After release, the FSM ignores the still-low AS until a fresh falling edge.

Source files
------------

// File: rtl/vme_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vme_slave_ctrl
// Purpose : VME A16/D16 slave bus-cycle controller for the control register
//           block. Synchronises the VME strobes, latches address and AM,
//           qualifies the cycle with the external decoder hit, issues
//           single-cycle register read/write strobes and runs the DTACK
//           handshake. Non-hit, wrong-AM, byte and timed-out cycles are
//           left unanswered so the crate bus timer ends them.
// Ports   : CLK, nRESET (async active-low)
//           VME_AS_N, VME_DS0_N, VME_DS1_N, VME_WRITE_N  - async bus strobes
//           VME_AM[5:0], VME_A[15:1], VME_D_IN[15:0]     - bus inputs
//           ADDR[15:0]      - latched address to the register decoder
//           ADDR_HIT        - OR of all decoder selects
//           RD_DATA[15:0]   - register mux data, valid 1 cycle after RD_STB
//           WR_DATA[15:0], WR_STB, RD_STB - register file interface
//           VME_D_OUT[15:0], VME_D_OE     - read data to bus transceiver
//           VME_DTACK_N, VME_DTACK_OE     - DTACK level and drive enable
// Revision: 1.0 - initial release
// ============================================================================
module vme_slave_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [5:0] AM_SUP      = 6'h2D,
   parameter logic [5:0] AM_USR      = 6'h29,
   parameter int         DTACK_DELAY = 2,
   parameter int         DS_TIMEOUT  = 255
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        VME_AS_N,
   input  logic        VME_DS0_N,
   input  logic        VME_DS1_N,
   input  logic        VME_WRITE_N,
   input  logic [5:0]  VME_AM,
   input  logic [15:1] VME_A,
   input  logic [15:0] VME_D_IN,
   output logic [15:0] ADDR,
   input  logic        ADDR_HIT,
   input  logic [15:0] RD_DATA,
   output logic [15:0] WR_DATA,
   output logic        WR_STB,
   output logic        RD_STB,
   output logic [15:0] VME_D_OUT,
   output logic        VME_D_OE,
   output logic        VME_DTACK_N,
   output logic        VME_DTACK_OE
);

   localparam int c_CNT_MAX = (DS_TIMEOUT > DTACK_DELAY) ? DS_TIMEOUT : DTACK_DELAY;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(DS_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_DELAY   = c_CNT_W'(DTACK_DELAY);
   localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

   // Synchroniser bit order: {WRITE_N, DS1_N, DS0_N, AS_N}.
   // AS resets to the asserted level so that an AS already held low when
   // reset is released never looks like a fresh falling edge.
   localparam logic [3:0] c_SYNC_RST = 4'b1110;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_DECODE    = 4'd1,
      S_WAIT_DS   = 4'd2,
      S_DS_SETTLE = 4'd3,
      S_STROBE    = 4'd4,
      S_DELAY     = 4'd5,
      S_ACK       = 4'd6,
      S_RELEASE   = 4'd7,
      S_IGNORE    = 4'd8
   } state_t;

   state_t                          r_state;
   logic [SYNC_STAGES-1:0][3:0]     r_sync;
   logic                            r_as_prev;
   logic [5:0]                      r_am;
   logic                            r_is_write;
   logic [c_CNT_W-1:0]              r_cnt;

   logic w_as_n, w_ds0_n, w_ds1_n, w_wr_n, w_as_fall, w_am_ok;

   assign w_as_n    = r_sync[SYNC_STAGES-1][0];
   assign w_ds0_n   = r_sync[SYNC_STAGES-1][1];
   assign w_ds1_n   = r_sync[SYNC_STAGES-1][2];
   assign w_wr_n    = r_sync[SYNC_STAGES-1][3];
   assign w_as_fall = r_as_prev & ~w_as_n;
   assign w_am_ok   = (r_am == AM_SUP) || (r_am == AM_USR);

   // Strobe synchronisers and AS edge history.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_sync    <= {SYNC_STAGES{c_SYNC_RST}};
         r_as_prev <= 1'b0;
      end else begin
         if (SYNC_STAGES > 1)
            r_sync <= {r_sync[SYNC_STAGES-2:0], {VME_WRITE_N, VME_DS1_N, VME_DS0_N, VME_AS_N}};
         else
            r_sync <= {VME_WRITE_N, VME_DS1_N, VME_DS0_N, VME_AS_N};
         r_as_prev <= w_as_n;
      end
   end

   // Bus-cycle FSM; every output is registered.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state      <= S_IDLE;
         r_am         <= '0;
         r_is_write   <= 1'b0;
         r_cnt        <= '0;
         ADDR         <= '0;
         WR_DATA      <= '0;
         VME_D_OUT    <= '0;
         WR_STB       <= 1'b0;
         RD_STB       <= 1'b0;
         VME_D_OE     <= 1'b0;
         VME_DTACK_N  <= 1'b1;
         VME_DTACK_OE <= 1'b0;
      end else begin
         WR_STB <= 1'b0;
         RD_STB <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_as_fall) begin
                  ADDR    <= {VME_A, 1'b0};
                  r_am    <= VME_AM;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_as_n)
                  r_state <= S_IDLE;
               else if (!w_am_ok || !ADDR_HIT)
                  r_state <= S_IGNORE;
               else begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT_DS;
               end
            end
            S_WAIT_DS: begin
               if (w_as_n)
                  r_state <= S_IDLE;
               else if (!w_ds0_n || !w_ds1_n)
                  r_state <= S_DS_SETTLE;
               else if (r_cnt == c_TIMEOUT)
                  r_state <= S_IGNORE;
               else
                  r_cnt <= r_cnt + c_ONE;
            end
            S_DS_SETTLE: begin
               // One extra cycle lets the second DS arrive; a lone DS is a
               // byte access, which this block does not answer.
               if (w_as_n)
                  r_state <= S_IDLE;
               else if (!w_ds0_n && !w_ds1_n) begin
                  r_is_write <= ~w_wr_n;
                  if (w_wr_n)
                     RD_STB <= 1'b1;
                  else begin
                     WR_STB  <= 1'b1;
                     WR_DATA <= VME_D_IN;
                  end
                  r_state <= S_STROBE;
               end else
                  r_state <= S_IGNORE;
            end
            S_STROBE: begin
               r_cnt   <= c_DELAY;
               r_state <= S_DELAY;
            end
            S_DELAY: begin
               // RD_DATA is valid on the first DELAY cycle; capture it there
               // and enable the transceiver together with the valid data.
               if (!r_is_write && (r_cnt == c_DELAY)) begin
                  VME_D_OUT <= RD_DATA;
                  VME_D_OE  <= 1'b1;
               end
               if (r_cnt <= c_ONE) begin
                  VME_DTACK_N  <= 1'b0;
                  VME_DTACK_OE <= 1'b1;
                  r_state      <= S_ACK;
               end else
                  r_cnt <= r_cnt - c_ONE;
            end
            S_ACK: begin
               if (w_ds0_n && w_ds1_n) begin
                  VME_DTACK_N <= 1'b1;   // actively drive high for one cycle
                  VME_D_OE    <= 1'b0;
                  r_state     <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               VME_DTACK_OE <= 1'b0;
               r_state      <= S_IDLE;
            end
            S_IGNORE: begin
               if (w_as_n)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
